// File: rtl/branch_resolution_unit.sv
// rtl/branch_resolution_unit.sv - branch prediction check, flush/redirect and predictor update
//
// Purpose:
//   Carries each IF-stage branch prediction down the ID and EX tracking
//   registers, compares it with the real outcome at EX, flushes and
//   redirects fetch on a mispredict, and writes the outcome back into the
//   predictor tables one cycle after resolution.
//
// Ports:
//   i_clk, i_rst_n           clock, synchronous active-low reset
//   i_stall                  freezes tracking registers and resolution
//   i_if_is_branch           IF instruction is a branch
//   i_if_pred_taken          predicted direction for the IF instruction
//   i_if_pred_target         predicted target for the IF instruction
//   i_if_pc                  IF-stage PC
//   i_ex_resolve             EX branch outcome valid this cycle
//   i_ex_taken, i_ex_target  actual direction and target
//   o_flush                  kill IF/ID and ID/EX (1-cycle pulse)
//   o_redirect_valid         load o_redirect_pc into PC (1-cycle pulse)
//   o_redirect_pc            corrected fetch address
//   o_upd_valid              predictor write enable
//   o_upd_idx                predictor entry, pc[IDX_W+1:2]
//   o_upd_taken              new BHT bit
//   o_upd_target             new BHB target
//   o_br_cnt, o_mis_cnt      saturating resolve/mispredict counters,
//                            present only when BRU_PERF_CNT_EN is defined

module branch_resolution_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_stall,
  input  logic                  i_if_is_branch,
  input  logic                  i_if_pred_taken,
  input  logic [DATA_WIDTH-1:0] i_if_pred_target,
  input  logic [DATA_WIDTH-1:0] i_if_pc,
  input  logic                  i_ex_resolve,
  input  logic                  i_ex_taken,
  input  logic [DATA_WIDTH-1:0] i_ex_target,
  output logic                  o_flush,
  output logic                  o_redirect_valid,
  output logic [DATA_WIDTH-1:0] o_redirect_pc,
  output logic                  o_upd_valid,
  output logic [IDX_W-1:0]      o_upd_idx,
  output logic                  o_upd_taken,
  output logic [DATA_WIDTH-1:0] o_upd_target
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]           o_br_cnt,
  output logic [31:0]           o_mis_cnt
`endif
);

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } state_t;

  state_t state, state_next;

  logic                  id_v, id_pred_taken;
  logic [DATA_WIDTH-1:0] id_pred_target, id_pc;
  logic                  ex_v, ex_pred_taken;
  logic [DATA_WIDTH-1:0] ex_pred_target, ex_pc;

  logic                  res, mis;
  logic [DATA_WIDTH-1:0] correct_pc;
  logic [DATA_WIDTH-1:0] redirect_pc_q;

  // Resolution is blocked while stalled (EX entry is retried after release)
  // and while recovering (EX content belongs to the squashed path).
  always_comb begin
    res        = ex_v & i_ex_resolve & ~i_stall & (state == IDLE);
    mis        = res & ((ex_pred_taken != i_ex_taken) |
                        (i_ex_taken & (ex_pred_target != i_ex_target)));
    correct_pc = i_ex_taken ? i_ex_target : (ex_pc + DATA_WIDTH'(4));
  end

  // Tracking registers; a mispredict invalidates both stages on the same edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      id_v           <= 1'b0;
      id_pred_taken  <= 1'b0;
      id_pred_target <= '0;
      id_pc          <= '0;
      ex_v           <= 1'b0;
      ex_pred_taken  <= 1'b0;
      ex_pred_target <= '0;
      ex_pc          <= '0;
    end else if (!i_stall) begin
      id_v           <= i_if_is_branch & ~mis;
      id_pred_taken  <= i_if_pred_taken;
      id_pred_target <= i_if_pred_target;
      id_pc          <= i_if_pc;
      ex_v           <= id_v & ~mis;
      ex_pred_taken  <= id_pred_taken;
      ex_pred_target <= id_pred_target;
      ex_pc          <= id_pc;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // FSM next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mis) state_next = RECOVER;
      RECOVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: the redirect address is held only for the RECOVER cycle.
  always_comb begin
    o_flush          = (state == RECOVER);
    o_redirect_valid = (state == RECOVER);
    o_redirect_pc    = (state == RECOVER) ? redirect_pc_q : '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)  redirect_pc_q <= '0;
    else if (mis)  redirect_pc_q <= correct_pc;
  end

  // Predictor write-back, issued for every resolved branch.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_upd_valid  <= 1'b0;
      o_upd_idx    <= '0;
      o_upd_taken  <= 1'b0;
      o_upd_target <= '0;
    end else begin
      o_upd_valid <= res;
      if (res) begin
        o_upd_idx    <= ex_pc[IDX_W+1:2];
        o_upd_taken  <= i_ex_taken;
        o_upd_target <= i_ex_target;
      end
    end
  end

`ifdef BRU_PERF_CNT_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_br_cnt  <= '0;
      o_mis_cnt <= '0;
    end else begin
      if (res && (o_br_cnt != 32'hFFFF_FFFF))  o_br_cnt  <= o_br_cnt + 32'd1;
      if (mis && (o_mis_cnt != 32'hFFFF_FFFF)) o_mis_cnt <= o_mis_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
// tb/tb_branch_resolution_unit.sv - directed self-checking bench for branch_resolution_unit
//
// Purpose:
//   Drives hand-written branch scenarios (correct prediction, direction and
//   target mispredicts, stall, back-to-back, untracked resolve, shadow squash,
//   PC wrap, reset during recovery, optional counters) and checks every
//   output against hand-computed values.
//
// Ports: none (top-level bench).

module tb_branch_resolution_unit;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_stall;
  logic        i_if_is_branch;
  logic        i_if_pred_taken;
  logic [31:0] i_if_pred_target;
  logic [31:0] i_if_pc;
  logic        i_ex_resolve;
  logic        i_ex_taken;
  logic [31:0] i_ex_target;
  logic        o_flush;
  logic        o_redirect_valid;
  logic [31:0] o_redirect_pc;
  logic        o_upd_valid;
  logic [2:0]  o_upd_idx;
  logic        o_upd_taken;
  logic [31:0] o_upd_target;
`ifdef BRU_PERF_CNT_EN
  logic [31:0] o_br_cnt;
  logic [31:0] o_mis_cnt;
`endif

  int checks = 0;
  int errors = 0;

  branch_resolution_unit #(.DATA_WIDTH(32), .IDX_W(3)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_stall          (i_stall),
    .i_if_is_branch   (i_if_is_branch),
    .i_if_pred_taken  (i_if_pred_taken),
    .i_if_pred_target (i_if_pred_target),
    .i_if_pc          (i_if_pc),
    .i_ex_resolve     (i_ex_resolve),
    .i_ex_taken       (i_ex_taken),
    .i_ex_target      (i_ex_target),
    .o_flush          (o_flush),
    .o_redirect_valid (o_redirect_valid),
    .o_redirect_pc    (o_redirect_pc),
    .o_upd_valid      (o_upd_valid),
    .o_upd_idx        (o_upd_idx),
    .o_upd_taken      (o_upd_taken),
    .o_upd_target     (o_upd_target)
`ifdef BRU_PERF_CNT_EN
    ,
    .o_br_cnt         (o_br_cnt),
    .o_mis_cnt        (o_mis_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_if(input logic br, input logic [31:0] pc, input logic pt, input logic [31:0] ptgt);
    i_if_is_branch   = br;
    i_if_pc          = pc;
    i_if_pred_taken  = pt;
    i_if_pred_target = ptgt;
  endtask

  task automatic drive_ex(input logic rv, input logic t, input logic [31:0] tgt);
    i_ex_resolve = rv;
    i_ex_taken   = t;
    i_ex_target  = tgt;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_flush"}, {31'd0, o_flush}, 32'd0);
    chk({tag, "_rv"},    {31'd0, o_redirect_valid}, 32'd0);
    chk({tag, "_upd"},   {31'd0, o_upd_valid}, 32'd0);
  endtask

  // One branch through IF -> ID -> EX, resolved in EX, outputs checked on the
  // following cycle and again one cycle later to confirm the pulses drop.
  task automatic run_branch(input string tag, input logic [31:0] pc, input logic pt,
                            input logic [31:0] ptgt, input logic at, input logic [31:0] atgt,
                            input logic exp_mis, input logic [31:0] exp_rpc, input logic [2:0] exp_idx);
    drive_if(1'b1, pc, pt, ptgt);
    step();
    drive_if(1'b0, 32'd0, 1'b0, 32'd0);
    step();
    drive_ex(1'b1, at, atgt);
    step();
    drive_ex(1'b0, 1'b0, 32'd0);
    chk({tag, "_upd_valid"},  {31'd0, o_upd_valid}, 32'd1);
    chk({tag, "_upd_idx"},    {29'd0, o_upd_idx}, {29'd0, exp_idx});
    chk({tag, "_upd_taken"},  {31'd0, o_upd_taken}, {31'd0, at});
    chk({tag, "_upd_target"}, o_upd_target, atgt);
    chk({tag, "_flush"},      {31'd0, o_flush}, {31'd0, exp_mis});
    chk({tag, "_rv"},         {31'd0, o_redirect_valid}, {31'd0, exp_mis});
    chk({tag, "_rpc"},        o_redirect_pc, exp_rpc);
    step();
    chk_quiet({tag, "_after"});
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_stall = 1'b0;
    drive_if(1'b0, 32'd0, 1'b0, 32'd0);
    drive_ex(1'b0, 1'b0, 32'd0);
    step();
    step();

    // Reset state
    chk("rst_flush",      {31'd0, o_flush}, 32'd0);
    chk("rst_rv",         {31'd0, o_redirect_valid}, 32'd0);
    chk("rst_rpc",        o_redirect_pc, 32'd0);
    chk("rst_upd_valid",  {31'd0, o_upd_valid}, 32'd0);
    chk("rst_upd_idx",    {29'd0, o_upd_idx}, 32'd0);
    chk("rst_upd_taken",  {31'd0, o_upd_taken}, 32'd0);
    chk("rst_upd_target", o_upd_target, 32'd0);
`ifdef BRU_PERF_CNT_EN
    chk("rst_br_cnt",  o_br_cnt, 32'd0);
    chk("rst_mis_cnt", o_mis_cnt, 32'd0);
`endif
    i_rst_n = 1'b1;
    step();

    // Five resolved branches, two of them mispredicted
    run_branch("corr",  32'h10, 1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0,  3'd4);
    run_branch("ntmis", 32'h20, 1'b1, 32'h80, 1'b0, 32'h0,  1'b1, 32'h24, 3'd0);
    run_branch("tgt",   32'h30, 1'b1, 32'h80, 1'b1, 32'h90, 1'b1, 32'h90, 3'd4);
    run_branch("corr2", 32'h14, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0,  3'd5);
    run_branch("corr3", 32'h1C, 1'b1, 32'h8,  1'b1, 32'h8,  1'b0, 32'h0,  3'd7);
`ifdef BRU_PERF_CNT_EN
    chk("cnt_br",  o_br_cnt, 32'd5);
    chk("cnt_mis", o_mis_cnt, 32'd2);
`endif

    // Predicted not taken, actually taken
    run_branch("ntt", 32'h08, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h200, 3'd2);

    // Stall held for 3 cycles while resolve is asserted
    drive_if(1'b1, 32'h14, 1'b0, 32'h0);
    step();
    drive_if(1'b0, 32'd0, 1'b0, 32'd0);
    step();
    i_stall = 1'b1;
    drive_ex(1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_quiet("stall");
    end
    i_stall = 1'b0;
    step();
    drive_ex(1'b0, 1'b0, 32'd0);
    chk("stall_rel_upd",   {31'd0, o_upd_valid}, 32'd1);
    chk("stall_rel_idx",   {29'd0, o_upd_idx}, 32'd5);
    chk("stall_rel_taken", {31'd0, o_upd_taken}, 32'd0);
    step();
    chk_quiet("stall_after");

    // Back-to-back correctly predicted branches
    drive_if(1'b1, 32'h50, 1'b1, 32'h60);
    step();
    drive_if(1'b1, 32'h54, 1'b0, 32'h0);
    step();
    drive_if(1'b0, 32'd0, 1'b0, 32'd0);
    drive_ex(1'b1, 1'b1, 32'h60);
    step();
    drive_ex(1'b1, 1'b0, 32'h0);
    chk("b2b_a_upd", {31'd0, o_upd_valid}, 32'd1);
    chk("b2b_a_idx", {29'd0, o_upd_idx}, 32'd4);
    chk("b2b_a_tk",  {31'd0, o_upd_taken}, 32'd1);
    chk("b2b_a_fl",  {31'd0, o_flush}, 32'd0);
    step();
    drive_ex(1'b0, 1'b0, 32'd0);
    chk("b2b_b_upd", {31'd0, o_upd_valid}, 32'd1);
    chk("b2b_b_idx", {29'd0, o_upd_idx}, 32'd5);
    chk("b2b_b_tk",  {31'd0, o_upd_taken}, 32'd0);
    step();
    chk_quiet("b2b_after");

    // Resolve with no tracked branch in EX
    drive_ex(1'b1, 1'b1, 32'h123);
    step();
    step();
    drive_ex(1'b0, 1'b0, 32'd0);
    chk_quiet("untracked");

    // Shadow squash: A mispredicts with B in ID and C in IF
    drive_if(1'b1, 32'h40, 1'b1, 32'h100);
    step();
    drive_if(1'b1, 32'h44, 1'b0, 32'h0);
    step();
    drive_if(1'b1, 32'h48, 1'b0, 32'h0);
    drive_ex(1'b1, 1'b0, 32'h0);
    step();
    drive_if(1'b0, 32'd0, 1'b0, 32'd0);
    chk("sq_flush", {31'd0, o_flush}, 32'd1);
    chk("sq_rpc",   o_redirect_pc, 32'h44);
    chk("sq_upd",   {31'd0, o_upd_valid}, 32'd1);
    chk("sq_idx",   {29'd0, o_upd_idx}, 32'd0);
    step();
    chk_quiet("sq_recover");
    step();
    chk_quiet("sq_idle");
    drive_ex(1'b0, 1'b0, 32'd0);
    step();

    // PC wrap
    run_branch("wrap", 32'hFFFF_FFFC, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h0, 3'd7);

    // Reset while in RECOVER
    drive_if(1'b1, 32'h60, 1'b1, 32'h300);
    step();
    drive_if(1'b0, 32'd0, 1'b0, 32'd0);
    step();
    drive_ex(1'b1, 1'b0, 32'h0);
    step();
    drive_ex(1'b0, 1'b0, 32'd0);
    chk("rr_flush_pre", {31'd0, o_flush}, 32'd1);
    chk("rr_rpc_pre",   o_redirect_pc, 32'h64);
    i_rst_n = 1'b0;
    step();
    chk_quiet("rr");
    chk("rr_rpc", o_redirect_pc, 32'd0);
`ifdef BRU_PERF_CNT_EN
    chk("rr_br_cnt", o_br_cnt, 32'd0);
`endif
    i_rst_n = 1'b1;
    step();
    chk_quiet("rr_post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
